mem_port_arbiter: RTL

- Shares the core's single memory port between the IFU (instruction fetch) and the LSU (load/store).
- Serialises exactly one outstanding transaction at a time.
- The LSU has priority, with a bounded-streak anti-starvation rule for the IFU.
- A response-timeout watchdog returns an error instead of hanging the pipeline.
- Sits between the IFU/LSU stages and the memory/bus bridge.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the IFU and the LSU.
//
// One transaction is in flight at a time (IDLE -> REQ -> WAIT_RSP -> RSP).
// The LSU normally wins arbitration. After MAX_LSU_STREAK consecutive LSU
// grants while the IFU was waiting, the IFU is forced to win. A watchdog
// synthesises an error response after TIMEOUT_CYCLES in WAIT_RSP
// (0 disables it). Responses that arrive outside WAIT_RSP are dropped and
// flagged on stray_rsp.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   ifu_req_* / ifu_rsp_*             IFU request/response handshakes
//   lsu_req_* / lsu_rsp_*             LSU request/response handshakes
//   mem_req_* / mem_rsp_*             downstream memory port (registered request)
//   stray_rsp                         one-cycle pulse per dropped response
module mem_port_arbiter #(
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rsp_rdata,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wstrb,
  output logic        lsu_rsp_valid,
  input  logic        lsu_rsp_ready,
  output logic [31:0] lsu_rsp_rdata,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err,
  output logic        stray_rsp
);

  // Counter only needs to reach TIMEOUT_CYCLES - 1.
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0]  StreakMax = 4'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StRsp} state_e;

  state_e          state_q;
  logic            owner_q;  // 0 = IFU, 1 = LSU
  logic [3:0]      streak_q;
  logic [TmoW-1:0] tmo_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic in_idle;
  logic lsu_win;
  logic tmo_hit;
  logic owner_rsp_ready;

  assign in_idle = (state_q == StIdle);
  // LSU wins unless the IFU is waiting and the LSU streak is exhausted.
  assign lsu_win = lsu_req_valid && !(ifu_req_valid && (streak_q == StreakMax));
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign owner_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;

  // Combinational readies are gated by rst_n so every handshake output is
  // low while reset is held.
  assign lsu_req_ready = rst_n && in_idle && lsu_win;
  assign ifu_req_ready = rst_n && in_idle && ifu_req_valid && !lsu_win;
  assign mem_req_valid = (state_q == StReq);
  assign mem_rsp_ready = rst_n && (state_q != StRsp);

  assign ifu_rsp_valid = (state_q == StRsp) && !owner_q;
  assign lsu_rsp_valid = (state_q == StRsp) && owner_q;
  assign ifu_rsp_rdata = rsp_rdata_q;
  assign ifu_rsp_err   = rsp_err_q;
  assign lsu_rsp_rdata = rsp_rdata_q;
  assign lsu_rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      streak_q      <= '0;
      tmo_q         <= '0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      stray_rsp     <= 1'b0;
    end else begin
      // Anything the memory returns outside WAIT_RSP is a late reply.
      stray_rsp <= mem_rsp_valid && ((state_q == StIdle) || (state_q == StReq));

      unique case (state_q)
        StIdle: begin
          if (lsu_win) begin
            mem_req_addr  <= lsu_req_addr;
            mem_req_wen   <= lsu_req_wen;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_wstrb <= lsu_req_wstrb;
            owner_q       <= 1'b1;
            state_q       <= StReq;
            if (!ifu_req_valid) begin
              streak_q <= '0;
            end else if (streak_q != StreakMax) begin
              streak_q <= streak_q + 4'd1;
            end
          end else if (ifu_req_valid) begin
            mem_req_addr  <= ifu_req_addr;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= 4'b0000;
            owner_q       <= 1'b0;
            streak_q      <= '0;
            state_q       <= StReq;
          end else begin
            streak_q <= '0;
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            tmo_q   <= '0;
            state_q <= StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (mem_rsp_valid) begin
            // Stores never return data to the LSU.
            rsp_rdata_q <= (owner_q && mem_req_wen) ? 32'h0 : mem_rsp_rdata;
            rsp_err_q   <= mem_rsp_err;
            state_q     <= StRsp;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (tmo_hit) begin
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              state_q     <= StRsp;
            end
          end
        end
        StRsp: begin
          if (owner_rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
